rom_16x4: RTL and testbench

- Synchronous read-only lookup table with 16 words of 4 bits and a registered output.
- Used as a small constant table (a 4-bit substitution box) inside datapaths.
- One read per enabled clock edge; output is held while the block is disabled.

---
 rtl/rom_16x4.sv | 57 +++++
 tb/tb_rom_16x4.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_16x4.sv
// 16x4 constant lookup table (4-bit substitution box) with a registered read port.
// One read per enabled clock edge; data holds while en is low.
module rom_16x4 #(
  parameter int                 ADDR_W     = 4,
  parameter int                 DATA_W     = 4,
  parameter logic [DATA_W-1:0]  RESET_DATA = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  // valid/data contract: no handshake, no backpressure. A rising edge with en=1
  // captures ROM[addr] into data and raises valid for exactly the following
  // cycle; an edge with en=0 keeps data and drops valid.
  logic [DATA_W-1:0] lookup;

  // Unknown (X/Z) addresses fall through to the default arm and read as zero.
  always_comb begin
    lookup = '0;
    case (addr)
      4'h0:    lookup = 4'hE;
      4'h1:    lookup = 4'h4;
      4'h2:    lookup = 4'hD;
      4'h3:    lookup = 4'h1;
      4'h4:    lookup = 4'h2;
      4'h5:    lookup = 4'hF;
      4'h6:    lookup = 4'hB;
      4'h7:    lookup = 4'h8;
      4'h8:    lookup = 4'h3;
      4'h9:    lookup = 4'hA;
      4'hA:    lookup = 4'h6;
      4'hB:    lookup = 4'hC;
      4'hC:    lookup = 4'h5;
      4'hD:    lookup = 4'h9;
      4'hE:    lookup = 4'h0;
      4'hF:    lookup = 4'h7;
      default: lookup = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= RESET_DATA;
      valid <= 1'b0;
    end else if (en) begin
      data  <= lookup;
      valid <= 1'b1;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_16x4.sv
// Self-checking bench for rom_16x4: directed scenarios plus random reads
// compared against a table-driven reference model.
module tb_rom_16x4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] addr;
  logic [3:0] data;
  logic       valid;

  int checks = 0;
  int errors = 0;

  // Expected {valid, data} after each clock edge.
  logic [4:0] exp_q[$];
  logic [3:0] rom_tab[16] = '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
                              4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7};
  logic [3:0] model_data;

  rom_16x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .addr  (addr),
    .data  (data),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs, step past the edge, and queue the model's prediction.
  task automatic do_cycle(input logic e, input logic [3:0] a);
    logic v;
    en   = e;
    addr = a;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_data = 4'h0;
      v = 1'b0;
    end else if (e) begin
      model_data = $isunknown(a) ? 4'h0 : rom_tab[a];
      v = 1'b1;
    end else begin
      v = 1'b0;
    end
    exp_q.push_back({v, model_data});
  endtask

  task automatic test_reset();
    logic [4:0] exp;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, data} !== 5'h00) begin
      errors++;
      $display("FAIL reset_async: got valid=%b data=%h, want valid=0 data=0", valid, data);
    end
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 4'hA);
      exp = exp_q.pop_front();
      checks++;
      if ({valid, data} !== exp) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got valid=%b data=%h, want valid=%b data=%h",
                 i, valid, data, exp[4], exp[3:0]);
      end
    end
    rst_n = 1'b1;
    do_cycle(1'b1, 4'hA);
    exp = exp_q.pop_front();
    checks++;
    if ({valid, data} !== 5'h16 || {valid, data} !== exp) begin
      errors++;
      $display("FAIL reset_release: got valid=%b data=%h, want valid=1 data=6", valid, data);
    end
  endtask

  task automatic test_sequential();
    logic [3:0] addrs[3] = '{4'hA, 4'h6, 4'h3};
    logic [3:0] want[3]  = '{4'h6, 4'hB, 4'h1};
    logic [4:0] exp;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, addrs[i]);
      exp = exp_q.pop_front();
      checks++;
      if ({valid, data} !== {1'b1, want[i]} || {valid, data} !== exp) begin
        errors++;
        $display("FAIL seq_read[%0d]: got valid=%b data=%h, want valid=1 data=%h",
                 i, valid, data, want[i]);
      end
    end
  endtask

  task automatic test_enable_low();
    logic [4:0] exp;
    do_cycle(1'b0, 4'hF);
    exp = exp_q.pop_front();
    checks++;
    if ({valid, data} !== 5'h01 || {valid, data} !== exp) begin
      errors++;
      $display("FAIL en_low_hold: got valid=%b data=%h, want valid=0 data=1", valid, data);
    end
    do_cycle(1'b1, 4'hF);
    exp = exp_q.pop_front();
    checks++;
    if ({valid, data} !== 5'h17 || {valid, data} !== exp) begin
      errors++;
      $display("FAIL en_resume: got valid=%b data=%h, want valid=1 data=7", valid, data);
    end
  endtask

  task automatic test_unknown_addr();
    logic [4:0] exp;
    logic [3:0] xa;
    do_cycle(1'b1, 4'h8);
    exp = exp_q.pop_front();
    checks++;
    if ({valid, data} !== 5'h13 || {valid, data} !== exp) begin
      errors++;
      $display("FAIL read_8: got valid=%b data=%h, want valid=1 data=3", valid, data);
    end
    do_cycle(1'b1, 4'h0);
    exp = exp_q.pop_front();
    checks++;
    if ({valid, data} !== 5'h1E || {valid, data} !== exp) begin
      errors++;
      $display("FAIL read_0: got valid=%b data=%h, want valid=1 data=e", valid, data);
    end
    xa = 4'bxxxx;
    do_cycle(1'b1, xa);
    exp = exp_q.pop_front();
    checks++;
    if ({valid, data} !== exp) begin
      errors++;
      $display("FAIL read_unknown: got valid=%b data=%h, want valid=%b data=%h",
               valid, data, exp[4], exp[3:0]);
    end
  endtask

  task automatic test_sweep();
    logic [4:0] exp;
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b1, 4'(i));
      exp = exp_q.pop_front();
      checks++;
      if ({valid, data} !== exp) begin
        errors++;
        $display("FAIL sweep[%0h]: got valid=%b data=%h, want valid=%b data=%h",
                 i, valid, data, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    logic [3:0] a;
    logic       e;
    for (int i = 0; i < 60; i++) begin
      e = ($urandom_range(0, 3) != 0);
      a = 4'($urandom_range(0, 15));
      if (i % 10 < 3) a = 4'h5;   // repeated-address runs
      do_cycle(e, a);
      exp = exp_q.pop_front();
      checks++;
      if ({valid, data} !== exp) begin
        errors++;
        $display("FAIL random[%0d]: en=%b addr=%h got valid=%b data=%h, want valid=%b data=%h",
                 i, e, a, valid, data, exp[4], exp[3:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] exp;
    do_cycle(1'b1, 4'h5);
    exp = exp_q.pop_front();
    checks++;
    if ({valid, data} !== 5'h1F || {valid, data} !== exp) begin
      errors++;
      $display("FAIL pre_reset_read: got valid=%b data=%h, want valid=1 data=f", valid, data);
    end
    en   = 1'b1;
    addr = 4'hB;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, data} !== 5'h00) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b data=%h, want valid=0 data=0", valid, data);
    end
    model_data = 4'h0;
    do_cycle(1'b1, 4'hB);
    exp = exp_q.pop_front();
    checks++;
    if ({valid, data} !== exp) begin
      errors++;
      $display("FAIL mid_reset_hold: got valid=%b data=%h, want valid=%b data=%h",
               valid, data, exp[4], exp[3:0]);
    end
    rst_n = 1'b1;
    do_cycle(1'b1, 4'hB);
    exp = exp_q.pop_front();
    checks++;
    if ({valid, data} !== 5'h1C || {valid, data} !== exp) begin
      errors++;
      $display("FAIL post_reset_read: got valid=%b data=%h, want valid=1 data=c", valid, data);
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    en         = 1'b1;
    addr       = 4'hA;
    model_data = 4'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_enable_low();
    test_unknown_addr();
    test_sweep();
    test_back_to_back();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
